// File: rtl/shift_normalizer_pkg.sv
// shift_normalizer_pkg: shared widths, FSM states and mode encoding for the normalizer
package shift_normalizer_pkg;
  localparam int WIDTH = 32;
  localparam int SHW = 5;
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED = 1'b1;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/shift_normalizer_if.sv
// shift_normalizer_if: operand/result valid-ready handshake bundle
interface shift_normalizer_if #(parameter int WIDTH = 32, parameter int SHW = 5);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic signed_mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] Y;
  logic [SHW-1:0] shamt;
  logic zero;
  modport master (output in_valid, A, signed_mode, out_ready, input in_ready, out_valid, Y, shamt, zero);
  modport slave (input in_valid, A, signed_mode, out_ready, output in_ready, out_valid, Y, shamt, zero);
endinterface

// File: rtl/shift_normalizer_norm_step.sv
// norm_step: one binary-search step, tests whether the top 2^k bits are redundant
module norm_step import shift_normalizer_pkg::*; #(
  parameter int WIDTH = shift_normalizer_pkg::WIDTH,
  parameter int SHW = shift_normalizer_pkg::SHW
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [SHW-1:0]   i_k,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_val,
  output logic             o_hit
);
  logic [WIDTH-1:0] w_w, w_top_u, w_top_s;
  assign w_w = WIDTH'(1) << i_k;
  assign w_top_u = i_val >> (WIDTH'(WIDTH) - w_w);
  // arithmetic shift keeps w+1 top bits; they are all equal iff result is 0 or all ones
  assign w_top_s = $signed(i_val) >>> (WIDTH'(WIDTH - 1) - w_w);
  assign o_hit = (i_mode == MODE_SIGNED) ? (w_top_s == '0 || &w_top_s) : (w_top_u == '0);
  assign o_val = i_val << w_w;
endmodule

// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle leading-zero / redundant-sign normalizer with valid-ready handshakes
module shift_normalizer import shift_normalizer_pkg::*; #(
  parameter int WIDTH = shift_normalizer_pkg::WIDTH,
  parameter int SHW = shift_normalizer_pkg::SHW
) (
  input logic clk,
  input logic rst,
  shift_normalizer_if.slave bus
);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_work, w_step_val;
  logic [SHW-1:0] r_cnt, r_k;
  logic r_mode, r_zero, w_hit;
  norm_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
    .i_val(r_work),
    .i_k(r_k),
    .i_mode(r_mode),
    .o_val(w_step_val),
    .o_hit(w_hit)
  );
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)   ? (bus.in_valid ? SEARCH : IDLE) :
             (r_state == SEARCH) ? ((r_k == '0) ? DONE : SEARCH) :
                                   (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_work <= '0;
      r_cnt <= '0;
      r_k <= '0;
      r_mode <= MODE_UNSIGNED;
      r_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_work <= bus.A;
        r_mode <= bus.signed_mode;
        r_cnt <= '0;
        r_k <= SHW'(SHW - 1);
        r_zero <= (bus.A == '0);
      end else if (r_state == SEARCH) begin
        r_k <= r_k - SHW'(1);
        if (w_hit) begin
          r_work <= w_step_val;
          r_cnt <= r_cnt + (SHW'(1) << r_k);
        end
      end
    end
  end
  assign bus.in_ready = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.Y = r_work;
  assign bus.shamt = r_cnt;
  assign bus.zero = r_zero;
endmodule
